data_mem_port: RTL and testbench

Data-side memory responder for the single-cycle core. It sits between the core's store/load outputs (MemWrite, ALUResult as address, WriteData) and a slower handshaked data memory. Stores are posted into a small write buffer and drained in order. Loads are answered from the youngest matching buffered store, or by a memory read while the core is stalled.

---
 rtl/mem_port_pkg.sv | 21 ++
 rtl/store_fifo.sv | 89 ++++++++
 rtl/data_mem_port.sv | 152 +++++++++++++++
 tb/tb_data_mem_port.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared types and default widths for the data-side memory port.
// Modules take these defaults and may override them per instance.
package mem_port_pkg;

  localparam int DEPTH_D  = 4;
  localparam int ADDR_W_D = 32;
  localparam int DATA_W_D = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  // One buffered store at the default widths.
  typedef struct packed {
    logic [ADDR_W_D-3:0] addr_word;
    logic [DATA_W_D-1:0] data;
  } entry_t;

endpackage

// File: rtl/store_fifo.sv
// In-order write buffer for posted stores, with a parallel
// address search that returns the youngest matching entry.
module store_fifo
  import mem_port_pkg::*;
#(
  parameter int DEPTH = DEPTH_D,
  parameter int AW    = ADDR_W_D - 2,
  parameter int DW    = DATA_W_D,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic [AW-1:0] lookup_addr,
  output logic          hit,
  output logic [DW-1:0] hit_data,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  typedef struct packed {
    logic [AW-1:0] addr_word;
    logic [DW-1:0] data;
  } slot_t;

  slot_t         slots [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] idx;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A push into a full buffer is legal only alongside a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign head_addr = slots[head].addr_word;
  assign head_data = slots[head].data;

  always_ff @(posedge clk) begin
    if (do_push) begin
      slots[tail] <= '{addr_word: push_addr,
                       data:      push_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        tail <= tail + PW'(1);
      end
      if (do_pop) begin
        head <= head + PW'(1);
      end
      count <= count + CW'(do_push)
                     - CW'(do_pop);
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count &&
          slots[idx].addr_word == lookup_addr) begin
        hit      = 1'b1;
        hit_data = slots[idx].data;
      end
    end
  end

endmodule

// File: rtl/data_mem_port.sv
// Data-side memory responder: posts stores into a write buffer,
// drains them in order and serves loads from buffer or memory.
module data_mem_port
  import mem_port_pkg::*;
#(
  parameter int DEPTH  = DEPTH_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int AW = ADDR_W - 2;
  localparam int CW = $clog2(DEPTH) + 1;

  state_t state;
  state_t state_n;

  logic              req_n;
  logic              we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;

  logic [AW-1:0]     word;
  logic              ld;
  logic              wr_ack;
  logic              rd_ack;
  logic              push;
  logic              pop;

  logic              hit;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] hit_data;
  logic [AW-1:0]     head_addr;
  logic [DATA_W-1:0] head_data;
  logic [CW-1:0]     count;
  logic              unused_bits;

  assign word        = ALUResult[ADDR_W-1:2];
  assign unused_bits = ^{ALUResult[1:0], count};

  // A simultaneous store wins; the load is dropped.
  assign ld     = MemRead & ~MemWrite;
  assign wr_ack = (state == WR_WAIT) & mem_ack;
  assign rd_ack = (state == RD_WAIT) & mem_ack;

  assign Stall = reset &
                 ((MemWrite & full & ~wr_ack) |
                  (ld & ~hit & ~rd_ack));

  assign push = reset & MemWrite & ~Stall;
  assign pop  = reset & wr_ack;

  store_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push        (push),
    .push_addr   (word),
    .push_data   (WriteData),
    .pop         (pop),
    .lookup_addr (word),
    .hit         (hit),
    .hit_data    (hit_data),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .full        (full),
    .empty       (empty),
    .count       (count)
  );

  always_comb begin
    ReadData = '0;
    if (reset && ld) begin
      if (hit) begin
        ReadData = hit_data;
      end else if (rd_ack) begin
        ReadData = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_n;
      mem_req   <= req_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
    end
  end

  // Bus fields hold from issue through ack; IDLE always
  // spends one cycle with mem_req low between transactions.
  always_comb begin
    state_n = state;
    req_n   = mem_req;
    we_n    = mem_we;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    unique case (state)
      IDLE: begin
        if (ld && !hit) begin
          state_n = RD_WAIT;
          req_n   = 1'b1;
          we_n    = 1'b0;
          addr_n  = {word, 2'b00};
        end else if (!empty) begin
          state_n = WR_WAIT;
          req_n   = 1'b1;
          we_n    = 1'b1;
          addr_n  = {head_addr, 2'b00};
          wdata_n = head_data;
        end
      end
      WR_WAIT, RD_WAIT: begin
        if (mem_ack) begin
          state_n = IDLE;
          req_n   = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        req_n   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_data_mem_port.sv
// Directed and randomized checks of data_mem_port against a
// queue model of the write buffer and a word memory array.
module tb_data_mem_port;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  data_mem_port #(
    .DEPTH  (DEPTH),
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mem_m [int unsigned];

  int          vectors = 0;
  int          miscompares = 0;
  bit          push_now;
  bit          pop_now;
  bit          rst_now;
  bit          prev_rst = 1'b1;
  bit          prev_req;
  bit          prev_ack;
  logic [63:0] prev_bus;
  logic [31:0] prev_wdata;
  int          r;
  int          k;
  bit          hold;
  int          stall_run;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memval(logic [29:0] w);
    if (mem_m.exists(int'(w))) return mem_m[int'(w)];
    return {2'b10, w};
  endfunction

  // Compare this cycle's outputs to the model; runs mid-cycle.
  task automatic settle();
    bit          wr_ack;
    bit          rd_ack;
    bit          st;
    bit          ld;
    bit          hit;
    bit          exp_stall;
    logic [31:0] hd;
    logic [31:0] exp_rd;
    logic [29:0] w;
    #2;
    push_now = 1'b0;
    pop_now  = 1'b0;
    rst_now  = !reset;
    if (prev_rst) begin
      check("req_after_rst", 64'(mem_req), 64'(0));
    end else if (prev_req && !prev_ack) begin
      check("bus_hold", {30'd0, mem_req, mem_we, mem_addr},
            prev_bus);
      check("wdata_hold", 64'(mem_wdata), 64'(prev_wdata));
    end else if (prev_req) begin
      check("req_gap", 64'(mem_req), 64'(0));
    end
    prev_rst   = rst_now;
    prev_req   = mem_req;
    prev_ack   = mem_ack;
    prev_bus   = {30'd0, mem_req, mem_we, mem_addr};
    prev_wdata = mem_wdata;
    if (rst_now) begin
      check("rst_stall", 64'(Stall), 64'(0));
      return;
    end
    wr_ack = mem_req && mem_ack && mem_we;
    rd_ack = mem_req && mem_ack && !mem_we;
    w  = ALUResult[31:2];
    st = MemWrite;
    ld = MemRead && !MemWrite;
    hit = 1'b0;
    hd  = '0;
    foreach (q[i]) begin
      if (q[i].a == w) begin
        hit = 1'b1;
        hd  = q[i].d;
      end
    end
    if (wr_ack) begin
      check("drain_nonempty", 64'(q.size() > 0), 64'(1));
      if (q.size() > 0) begin
        check("drain_addr", 64'(mem_addr),
              {32'd0, q[0].a, 2'b00});
        check("drain_data", 64'(mem_wdata), 64'(q[0].d));
        pop_now = 1'b1;
      end
      mem_m[int'(mem_addr[31:2])] = mem_wdata;
    end
    exp_stall = (st && q.size() == DEPTH && !wr_ack) ||
                (ld && !hit && !rd_ack);
    exp_rd = '0;
    if (ld && hit) begin
      exp_rd = hd;
    end else if (ld && rd_ack) begin
      exp_rd = mem_rdata;
      check("rd_addr", 64'(mem_addr), {32'd0, w, 2'b00});
    end
    check("stall", 64'(Stall), 64'(exp_stall));
    check("rdata", 64'(ReadData), 64'(exp_rd));
    push_now = st && !exp_stall;
  endtask

  task automatic clock();
    @(posedge clk);
    if (rst_now) begin
      q.delete();
    end else begin
      if (pop_now) q.delete(0);
      if (push_now) q.push_back('{a: ALUResult[31:2],
                                  d: WriteData});
    end
    #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 100; c++) begin
      if (q.size() == 0 && !mem_req) break;
      mem_ack   = mem_req;
      mem_rdata = memval(mem_addr[31:2]);
      settle();
      clock();
    end
    mem_ack = 1'b0;
    check("drain_empty", 64'(q.size()), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    MemWrite  = 1'b1;
    MemRead   = 1'b0;
    ALUResult = 32'd100;
    WriteData = 32'd7;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    @(posedge clk);
    #1;

    // reset held with a store request present
    repeat (3) begin
      settle();
      check("rst_hold_stall", 64'(Stall), 64'(0));
      check("rst_hold_req", 64'(mem_req), 64'(0));
      clock();
    end
    reset = 1'b1;
    settle();
    check("st100_stall", 64'(Stall), 64'(0));
    clock();
    MemWrite = 1'b0;
    settle();
    check("req_early", 64'(mem_req), 64'(0));
    clock();
    repeat (2) begin
      settle();
      check("wr_bus", {30'd0, mem_req, mem_we, mem_addr},
            {30'd0, 1'b1, 1'b1, 32'd100});
      check("wr_data", 64'(mem_wdata), 64'(7));
      clock();
    end
    mem_ack = 1'b1;
    settle();
    clock();
    mem_ack = 1'b0;
    settle();
    clock();
    settle();
    check("no_rst_enq", 64'(mem_req), 64'(0));
    clock();

    // buffered loads: forward, then youngest
    MemWrite = 1'b1;
    settle();
    clock();
    MemWrite = 1'b0;
    MemRead  = 1'b1;
    settle();
    check("hit_stall", 64'(Stall), 64'(0));
    check("hit_data", 64'(ReadData), 64'(7));
    clock();
    MemRead   = 1'b0;
    MemWrite  = 1'b1;
    WriteData = 32'd9;
    settle();
    check("st2_stall", 64'(Stall), 64'(0));
    clock();
    MemWrite = 1'b0;
    MemRead  = 1'b1;
    settle();
    check("young_stall", 64'(Stall), 64'(0));
    check("young_data", 64'(ReadData), 64'(9));
    clock();
    MemRead = 1'b0;
    drain();

    // load miss with a three-cycle memory
    MemRead   = 1'b1;
    ALUResult = 32'd96;
    settle();
    check("miss_c0", 64'(Stall), 64'(1));
    clock();
    settle();
    check("miss_c1", 64'(Stall), 64'(1));
    check("miss_bus", {30'd0, mem_req, mem_we, mem_addr},
          {30'd0, 1'b1, 1'b0, 32'd96});
    clock();
    settle();
    check("miss_c2", 64'(Stall), 64'(1));
    clock();
    mem_ack   = 1'b1;
    mem_rdata = 32'h55;
    settle();
    check("miss_ack_stall", 64'(Stall), 64'(0));
    check("miss_ack_data", 64'(ReadData), 64'(32'h55));
    clock();
    MemRead = 1'b0;
    mem_ack = 1'b0;
    settle();
    check("miss_after", 64'(Stall), 64'(0));
    check("miss_rd_idle", 64'(ReadData), 64'(0));
    clock();

    // fill the buffer, overflow, accept on drain ack
    MemWrite = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ALUResult = 32'(4 * i);
      WriteData = 32'(256 + i);
      settle();
      check("fill_stall", 64'(Stall), 64'(0));
      clock();
    end
    ALUResult = 32'(4 * DEPTH);
    WriteData = 32'(256 + DEPTH);
    settle();
    check("full_stall", 64'(Stall), 64'(1));
    clock();
    mem_ack = 1'b1;
    settle();
    check("full_accept", 64'(Stall), 64'(0));
    check("first_drain", 64'(mem_addr), 64'(0));
    clock();
    MemWrite = 1'b0;
    mem_ack  = 1'b0;
    k = 1;
    for (int c = 0; c < 80 && k <= DEPTH; c++) begin
      mem_ack = mem_req;
      settle();
      if (mem_req) begin
        check("order_addr", 64'(mem_addr), 64'(4 * k));
        check("order_data", 64'(mem_wdata), 64'(256 + k));
        k++;
      end
      clock();
    end
    mem_ack = 1'b0;
    check("order_count", 64'(k), 64'(DEPTH + 1));

    // read miss beats a pending drain
    MemWrite  = 1'b1;
    ALUResult = 32'd200;
    WriteData = 32'h22;
    settle();
    clock();
    MemWrite  = 1'b0;
    MemRead   = 1'b1;
    ALUResult = 32'd300;
    settle();
    check("prio_stall", 64'(Stall), 64'(1));
    check("prio_idle", 64'(mem_req), 64'(0));
    clock();
    mem_ack   = 1'b1;
    mem_rdata = 32'h77;
    settle();
    check("prio_bus", {30'd0, mem_req, mem_we, mem_addr},
          {30'd0, 1'b1, 1'b0, 32'd300});
    check("prio_data", 64'(ReadData), 64'(32'h77));
    clock();
    MemRead = 1'b0;
    mem_ack = 1'b0;
    settle();
    clock();
    settle();
    check("prio_then_wr", {30'd0, mem_req, mem_we, mem_addr},
          {30'd0, 1'b1, 1'b1, 32'd200});
    clock();
    drain();

    // reset in the middle of a drain
    MemWrite = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ALUResult = 32'(400 + 4 * i);
      WriteData = 32'(1 + i);
      settle();
      clock();
    end
    MemWrite = 1'b0;
    reset    = 1'b0;
    settle();
    check("rst_inflight", 64'(mem_req), 64'(1));
    clock();
    reset   = 1'b1;
    mem_ack = 1'b1;
    settle();
    check("rst_req", 64'(mem_req), 64'(0));
    clock();
    mem_ack = 1'b0;
    settle();
    check("rst_nodrain", 64'(mem_req), 64'(0));
    clock();
    MemRead   = 1'b1;
    ALUResult = 32'd400;
    settle();
    check("rst_miss", 64'(Stall), 64'(1));
    clock();
    mem_ack   = 1'b1;
    mem_rdata = 32'hAB;
    settle();
    check("rst_rd_bus", {30'd0, mem_req, mem_we, mem_addr},
          {30'd0, 1'b1, 1'b0, 32'd400});
    check("rst_rd_data", 64'(ReadData), 64'(32'hAB));
    clock();
    MemRead = 1'b0;
    mem_ack = 1'b0;
    settle();
    clock();

    // random traffic; a stalled request is held
    hold      = 1'b0;
    stall_run = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!hold) begin
        r         = int'($urandom_range(0, 99));
        MemWrite  = (r < 45);
        MemRead   = (r >= 40 && r < 75);
        ALUResult = 32'($urandom_range(0, 7) * 4 +
                        $urandom_range(0, 3));
        WriteData = $urandom;
      end
      mem_ack   = mem_req && ($urandom_range(0, 2) != 0);
      mem_rdata = mem_req ? memval(mem_addr[31:2])
                          : $urandom;
      settle();
      hold      = Stall;
      stall_run = Stall ? stall_run + 1 : 0;
      if (stall_run > 60) begin
        check("stall_bound", 64'(stall_run), 64'(0));
        break;
      end
      clock();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
